// File: rtl/serial_sub_arbiter_if.sv
// Signal bundle for the two-requester serial subtractor: requests and operands in,
// grants, status and the registered result out.
interface serial_sub_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output req0, req1, a0, b0, a1, b1,
    input  gnt0, gnt1, busy, done, done_id, diff, borrow
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1,
    output gnt0, gnt1, busy, done, done_id, diff, borrow
  );
endinterface

// File: rtl/serial_sub_arbiter.sv
// Round-robin arbiter in front of a bit-serial (LSB-first) subtractor shared by two
// requesters; one WIDTH-cycle subtraction per grant, result held until the next one.
module serial_sub_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_sub_arbiter_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("serial_sub_arbiter: WIDTH must be in 2..32");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Two cascaded half subtractors: {borrow_out, difference}.
  function automatic logic [1:0] sub_bit(input logic a, input logic b, input logic bin);
    logic hd;
    logic hb;
    hd = a ^ b;
    hb = ~a & b;
    return {hb | (~hd & bin), hd ^ bin};
  endfunction

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  logic             bor_q, bor_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             done_id_q, done_id_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-2:0] res_q, res_d;

  logic             any_req;
  logic             win;
  logic             last_bit;
  logic [1:0]       sb;
  logic [WIDTH-1:0] res_cat;

  logic             gnt0_o, gnt1_o, busy_o, done_o;

  assign any_req  = bus.req0 | bus.req1;
  // Tie goes to the pointer; a lone request wins outright.
  assign win      = (bus.req0 && bus.req1) ? prio_q : bus.req1;
  assign last_bit = (cnt_q == CW'(WIDTH - 1));
  assign sb       = sub_bit(a_sr_q[0], b_sr_q[0], bor_q);
  assign res_cat  = {sb[0], res_q};

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (any_req)  state_d = S_SHIFT;
      S_SHIFT: if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : outputs
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    busy_o = (state_q != S_IDLE);
    done_o = (state_q == S_DONE);
    if (state_q == S_SHIFT && cnt_q == '0) begin
      gnt0_o = ~owner_q;
      gnt1_o = owner_q;
    end
  end

  always_comb begin : datapath_next
    cnt_d     = cnt_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    bor_d     = bor_q;
    diff_d    = diff_q;
    borrow_d  = borrow_q;
    done_id_d = done_id_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    res_d     = res_q;
    if (state_q == S_IDLE && any_req) begin
      a_sr_d  = win ? bus.a1 : bus.a0;
      b_sr_d  = win ? bus.b1 : bus.b0;
      bor_d   = 1'b0;
      cnt_d   = '0;
      owner_d = win;
      prio_d  = ~win;
    end else if (state_q == S_SHIFT) begin
      a_sr_d = a_sr_q >> 1;
      b_sr_d = b_sr_q >> 1;
      res_d  = res_cat[WIDTH-1:1];
      bor_d  = sb[1];
      cnt_d  = cnt_q + CW'(1);
      // The final bit goes straight into diff, so the shift register is one bit short.
      if (last_bit) begin
        diff_d    = res_cat;
        borrow_d  = sb[1];
        done_id_d = owner_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : ctrl_regs
    if (!rst_n) begin
      cnt_q     <= '0;
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      bor_q     <= 1'b0;
      diff_q    <= '0;
      borrow_q  <= 1'b0;
      done_id_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      prio_q    <= prio_d;
      owner_q   <= owner_d;
      bor_q     <= bor_d;
      diff_q    <= diff_d;
      borrow_q  <= borrow_d;
      done_id_q <= done_id_d;
    end
  end

  always_ff @(posedge clk) begin : data_regs
    a_sr_q <= a_sr_d;
    b_sr_q <= b_sr_d;
    res_q  <= res_d;
  end

  assign bus.gnt0    = gnt0_o;
  assign bus.gnt1    = gnt1_o;
  assign bus.busy    = busy_o;
  assign bus.done    = done_o;
  assign bus.done_id = done_id_q;
  assign bus.diff    = diff_q;
  assign bus.borrow  = borrow_q;

endmodule

// File: tb/tb_serial_sub_arbiter.sv
// Scoreboard bench: a transaction-level model predicts grant/done cycles and results,
// a monitor compares every cycle; directed scenarios plus a randomized phase.
module tb_serial_sub_arbiter;

  localparam int W = 8;
  typedef logic [W-1:0] word_t;
  typedef struct {
    logic  id;
    word_t diff;
    logic  borrow;
    int    gcyc;
    int    dcyc;
  } exp_t;

  logic clk;
  logic rst_n;

  serial_sub_arbiter_if #(.WIDTH(W)) bus ();

  serial_sub_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_until = 0;
  logic prio_m = 1'b0;
  exp_t sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic word_t rnd_op();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      default: return word_t'($urandom);
    endcase
  endfunction

  // Reference model: one subtraction occupies W+2 cycles from the sampling edge;
  // the result is plain modular subtraction and an unsigned compare.
  initial begin : model
    exp_t  e;
    logic  w;
    word_t a;
    word_t b;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        sb.delete();
        prio_m     = 1'b0;
        busy_until = cyc;
      end else begin
        cyc++;
        if (cyc >= busy_until && (bus.req0 || bus.req1)) begin
          w        = (bus.req0 && bus.req1) ? prio_m : bus.req1;
          a        = w ? bus.a1 : bus.a0;
          b        = w ? bus.b1 : bus.b0;
          e.id     = w;
          e.diff   = a - b;
          e.borrow = (a < b);
          e.gcyc   = cyc;
          e.dcyc   = cyc + W;
          sb.push_back(e);
          prio_m     = ~w;
          busy_until = cyc + W + 2;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (sb.size() != 0 && cyc == sb[0].gcyc) begin
          check("gnt0", 32'(bus.gnt0), 32'(!sb[0].id));
          check("gnt1", 32'(bus.gnt1), 32'(sb[0].id));
        end else begin
          check("no_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
        end
        check("busy", 32'(bus.busy), 32'(sb.size() != 0));
        if (sb.size() != 0 && cyc == sb[0].dcyc) begin
          e = sb.pop_front();
          check("done", 32'(bus.done), 32'd1);
          check("done_id", 32'(bus.done_id), 32'(e.id));
          check("diff", 32'(bus.diff), 32'(e.diff));
          check("borrow", 32'(bus.borrow), 32'(e.borrow));
        end else begin
          check("no_done", 32'(bus.done), 32'd0);
        end
      end
    end
  end

  task automatic wait_grant(input logic id, output int gc);
    gc = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (id ? bus.gnt1 : bus.gnt0) begin
        gc = cyc;
        break;
      end
    end
    check(id ? "gnt1_seen" : "gnt0_seen", 32'(gc >= 0), 32'd1);
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        dc = cyc;
        break;
      end
    end
    check("done_seen", 32'(dc >= 0), 32'd1);
  endtask

  task automatic wait_idle();
    int ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (!bus.busy) begin
        ok = 1;
        break;
      end
    end
    check("idle_seen", 32'(ok), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 32'({bus.gnt1, bus.gnt0}), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_done_id"}, 32'(bus.done_id), 32'd0);
    check({tag, "_diff"}, 32'(bus.diff), 32'd0);
    check({tag, "_borrow"}, 32'(bus.borrow), 32'd0);
  endtask

  initial begin : stimulus
    int    g, d, g1, n, first, ndone;
    int    gids[3];
    int    gcs[3];
    word_t hold;

    rst_n    = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.a0   = '0;
    bus.b0   = '0;
    bus.a1   = '0;
    bus.b1   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Basic subtraction; operand change after grant must not leak in.
    bus.a0   = 8'h35;
    bus.b0   = 8'h12;
    bus.req0 = 1'b1;
    wait_grant(1'b0, g);
    bus.req0 = 1'b0;
    bus.a0   = 8'hFF;
    wait_done(d);
    check("latency", 32'(d - g), 32'(W));
    check("r030_diff", 32'(bus.diff), 32'h23);
    check("r030_borrow", 32'(bus.borrow), 32'd0);
    check("r030_id", 32'(bus.done_id), 32'd0);

    bus.a1   = 8'h00;
    bus.b1   = 8'h01;
    bus.req1 = 1'b1;
    wait_grant(1'b1, g);
    bus.req1 = 1'b0;
    wait_done(d);
    check("r031a_diff", 32'(bus.diff), 32'hFF);
    check("r031a_borrow", 32'(bus.borrow), 32'd1);
    check("r031a_id", 32'(bus.done_id), 32'd1);

    bus.a1   = 8'hAA;
    bus.b1   = 8'hAA;
    bus.req1 = 1'b1;
    wait_grant(1'b1, g);
    bus.req1 = 1'b0;
    wait_done(d);
    check("r031b_diff", 32'(bus.diff), 32'h00);
    check("r031b_borrow", 32'(bus.borrow), 32'd0);

    // Reset lands in the DONE cycle, then both requests held: alternation and spacing.
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    bus.a0   = rnd_op();
    bus.b0   = rnd_op();
    bus.a1   = rnd_op();
    bus.b1   = rnd_op();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      gids[i] = -1;
      gcs[i]  = 0;
    end
    for (int i = 0; i < 60 && n < 3; i++) begin
      @(posedge clk);
      #1;
      if (bus.gnt0 || bus.gnt1) begin
        gids[n] = int'(bus.gnt1);
        gcs[n]  = cyc;
        n++;
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    check("rr_count", 32'(n), 32'd3);
    check("rr_first", 32'(gids[0]), 32'd0);
    check("rr_second", 32'(gids[1]), 32'd1);
    check("rr_third", 32'(gids[2]), 32'd0);
    check("rr_gap1", 32'(gcs[1] - gcs[0]), 32'(W + 2));
    check("rr_gap2", 32'(gcs[2] - gcs[1]), 32'(W + 2));
    wait_idle();

    // Late request from requester 1 waits; result registers hold during SHIFT.
    bus.a0   = rnd_op();
    bus.b0   = rnd_op();
    bus.req0 = 1'b1;
    wait_grant(1'b0, g);
    bus.req0 = 1'b0;
    hold     = bus.diff;
    repeat (3) @(posedge clk);
    #1;
    bus.a1   = rnd_op();
    bus.b1   = rnd_op();
    bus.req1 = 1'b1;
    check("hold_diff", 32'(bus.diff), 32'(hold));
    wait_done(d);
    wait_grant(1'b1, g1);
    bus.req1 = 1'b0;
    check("late_gnt1_gap", 32'(g1 - d), 32'd2);
    wait_done(d);

    // Reset in the 4th SHIFT cycle aborts the operation.
    bus.a0   = rnd_op();
    bus.b0   = rnd_op();
    bus.req0 = 1'b1;
    wait_grant(1'b0, g);
    bus.req0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_pre", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    bus.a0   = rnd_op();
    bus.b0   = rnd_op();
    bus.a1   = rnd_op();
    bus.b1   = rnd_op();
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    first = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.gnt0 || bus.gnt1) begin
        first = int'(bus.gnt1);
        break;
      end
    end
    bus.req0 = 1'b0;
    check("post_reset_prio", 32'(first), 32'd0);
    wait_grant(1'b1, g);
    bus.req1 = 1'b0;
    wait_idle();

    // Randomized traffic; each requester re-randomizes operands when granted.
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (bus.req0 && bus.gnt0) begin
        bus.req0 = 1'($urandom_range(0, 1));
        bus.a0   = rnd_op();
        bus.b0   = rnd_op();
      end else if (!bus.req0 && $urandom_range(0, 3) == 0) begin
        bus.req0 = 1'b1;
        bus.a0   = rnd_op();
        bus.b0   = rnd_op();
      end
      if (bus.req1 && bus.gnt1) begin
        bus.req1 = 1'($urandom_range(0, 1));
        bus.a1   = rnd_op();
        bus.b1   = rnd_op();
      end else if (!bus.req1 && $urandom_range(0, 3) == 0) begin
        bus.req1 = 1'b1;
        bus.a1   = rnd_op();
        bus.b1   = rnd_op();
      end
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
